// File: rtl/transaccion_multi.sv
// rtl/transaccion_multi.sv - multi-transaction card session unit with session withdrawal limit
// and a timed cash-dispense strobe.
module transaccion_multi #(
  parameter int          MONTO_W        = 32,
  parameter int          BAL_W          = 64,
  parameter int unsigned LIMITE_SESION  = 100000,
  parameter int          ENTREGA_CICLOS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tarjeta_recibida,
  input  logic               trans_valid,
  input  logic [1:0]         tipo_trans,
  input  logic [MONTO_W-1:0] monto,
  input  logic [BAL_W-1:0]   balance_inicial,
  output logic               trans_ready,
  output logic [BAL_W-1:0]   balance_actualizado,
  output logic               balance_stb,
  output logic               entregar_dinero,
  output logic               fondos_insuficientes,
  output logic               limite_excedido,
  output logic               error_trans
);

  localparam int CNT_W = $clog2(ENTREGA_CICLOS) + 1;

  typedef enum logic [1:0] {IDLE, SESION, EVALUAR, ENTREGA} estado_t;

  estado_t            estado_q, estado_d;
  logic [BAL_W-1:0]   balance_q, balance_d;
  logic [BAL_W-1:0]   retiro_q, retiro_d;
  logic [1:0]         tipo_q, tipo_d;
  logic [MONTO_W-1:0] monto_q, monto_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               stb_q, stb_d;
  logic               fondos_q, fondos_d;
  logic               limite_q, limite_d;
  logic               error_q, error_d;
  logic               entregar_q, entregar_d;

  // One spare bit so overflow and limit checks never wrap.
  logic [BAL_W:0] monto_ext, bal_ext, suma_dep, suma_ret, resta;
  assign monto_ext = (BAL_W+1)'(monto_q);
  assign bal_ext   = {1'b0, balance_q};
  assign suma_dep  = bal_ext + monto_ext;
  assign suma_ret  = {1'b0, retiro_q} + monto_ext;
  assign resta     = bal_ext - monto_ext;

  always_comb begin
    estado_d   = estado_q;
    balance_d  = balance_q;
    retiro_d   = retiro_q;
    tipo_d     = tipo_q;
    monto_d    = monto_q;
    cnt_d      = cnt_q;
    stb_d      = 1'b0;
    fondos_d   = 1'b0;
    limite_d   = 1'b0;
    error_d    = 1'b0;
    entregar_d = 1'b0;
    case (estado_q)
      IDLE: begin
        if (tarjeta_recibida) begin
          estado_d  = SESION;
          balance_d = balance_inicial;
          retiro_d  = '0;
        end
      end
      SESION: begin
        if (!tarjeta_recibida) begin
          estado_d  = IDLE;
          balance_d = '0;
          retiro_d  = '0;
        end else if (trans_valid) begin
          estado_d = EVALUAR;
          tipo_d   = tipo_trans;
          monto_d  = monto;
        end
      end
      EVALUAR: begin
        estado_d = SESION;
        case (tipo_q)
          2'b00: begin
            if (monto_q == '0 || suma_dep[BAL_W]) begin
              error_d = 1'b1;
            end else begin
              balance_d = suma_dep[BAL_W-1:0];
              stb_d     = 1'b1;
            end
          end
          2'b01: begin
            if (monto_q == '0) begin
              error_d = 1'b1;
            end else if (monto_ext > bal_ext) begin
              fondos_d = 1'b1;
            end else if (suma_ret > (BAL_W+1)'(LIMITE_SESION)) begin
              limite_d = 1'b1;
            end else begin
              balance_d  = resta[BAL_W-1:0];
              retiro_d   = suma_ret[BAL_W-1:0];
              stb_d      = 1'b1;
              entregar_d = 1'b1;
              cnt_d      = CNT_W'(ENTREGA_CICLOS - 1);
              estado_d   = ENTREGA;
            end
          end
          2'b10:   stb_d   = 1'b1;
          default: error_d = 1'b1;
        endcase
      end
      ENTREGA: begin
        if (cnt_q == '0) begin
          // Card pulled mid-dispense closes the session once the cash is out.
          if (tarjeta_recibida) begin
            estado_d = SESION;
          end else begin
            estado_d  = IDLE;
            balance_d = '0;
            retiro_d  = '0;
          end
        end else begin
          cnt_d      = cnt_q - CNT_W'(1);
          entregar_d = 1'b1;
        end
      end
      default: estado_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q   <= IDLE;
      balance_q  <= '0;
      retiro_q   <= '0;
      tipo_q     <= '0;
      monto_q    <= '0;
      cnt_q      <= '0;
      stb_q      <= 1'b0;
      fondos_q   <= 1'b0;
      limite_q   <= 1'b0;
      error_q    <= 1'b0;
      entregar_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      balance_q  <= balance_d;
      retiro_q   <= retiro_d;
      tipo_q     <= tipo_d;
      monto_q    <= monto_d;
      cnt_q      <= cnt_d;
      stb_q      <= stb_d;
      fondos_q   <= fondos_d;
      limite_q   <= limite_d;
      error_q    <= error_d;
      entregar_q <= entregar_d;
    end
  end

  assign trans_ready          = (estado_q == SESION) && tarjeta_recibida;
  assign balance_actualizado  = balance_q;
  assign balance_stb          = stb_q;
  assign fondos_insuficientes = fondos_q;
  assign limite_excedido      = limite_q;
  assign error_trans          = error_q;
  assign entregar_dinero      = entregar_q;

endmodule

// File: tb/tb_transaccion_multi.sv
// tb/tb_transaccion_multi.sv - directed and randomized bench for transaccion_multi.
module tb_transaccion_multi;
  localparam int          MW  = 32;
  localparam int          BW  = 64;
  localparam int unsigned LIM = 100000;
  localparam int          C   = 4;

  logic          clk = 1'b0;
  logic          reset, tarjeta, tv;
  logic [1:0]    tipo;
  logic [MW-1:0] monto;
  logic [BW-1:0] bini;
  logic          trans_ready, balance_stb, entregar, fondos, limite, error_trans;
  logic [BW-1:0] balance;

  transaccion_multi #(
    .MONTO_W(MW), .BAL_W(BW), .LIMITE_SESION(LIM), .ENTREGA_CICLOS(C)
  ) dut (
    .clk(clk), .reset(reset), .tarjeta_recibida(tarjeta), .trans_valid(tv),
    .tipo_trans(tipo), .monto(monto), .balance_inicial(bini),
    .trans_ready(trans_ready), .balance_actualizado(balance),
    .balance_stb(balance_stb), .entregar_dinero(entregar),
    .fondos_insuficientes(fondos), .limite_excedido(limite), .error_trans(error_trans)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errs = 0;
  logic [BW-1:0] m_bal, m_ret;

  typedef enum int {R_OK, R_DISP, R_FON, R_LIM, R_ERR} res_t;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Account rules applied directly to the model balance and session withdrawal total.
  task automatic model(input logic [1:0] t, input logic [MW-1:0] m, output res_t r);
    logic [BW:0] s;
    case (t)
      2'd0: begin
        s = {1'b0, m_bal} + {{(BW+1-MW){1'b0}}, m};
        if (m == 0 || s > {1'b0, {BW{1'b1}}}) r = R_ERR;
        else begin m_bal = s[BW-1:0]; r = R_OK; end
      end
      2'd1: begin
        if (m == 0) r = R_ERR;
        else if (BW'(m) > m_bal) r = R_FON;
        else if ({1'b0, m_ret} + (BW+1)'(m) > (BW+1)'(LIM)) r = R_LIM;
        else begin m_bal = m_bal - BW'(m); m_ret = m_ret + BW'(m); r = R_DISP; end
      end
      2'd2: r = R_OK;
      default: r = R_ERR;
    endcase
  endtask

  task automatic start_session(input logic [BW-1:0] b);
    tarjeta = 1'b1; bini = b;
    @(negedge clk);
    chk("start_ready", BW'(trans_ready), 1);
    chk("start_balance", balance, b);
    chk("start_no_stb", BW'(balance_stb), 0);
    m_bal = b; m_ret = 0;
  endtask

  task automatic end_session();
    tarjeta = 1'b0;
    @(negedge clk);
    chk("end_ready", BW'(trans_ready), 0);
    chk("end_balance", balance, 0);
  endtask

  task automatic trans(input logic [1:0] t, input logic [MW-1:0] m, input int drop_at, input int rst_at);
    res_t r;
    chk("ready_before", BW'(trans_ready), 1);
    tv = 1'b1; tipo = t; monto = m;
    @(negedge clk);
    tv = 1'b0; tipo = $urandom_range(0, 3); monto = $urandom;
    chk("ready_evaluar", BW'(trans_ready), 0);
    chk("quiet_evaluar", BW'({balance_stb, fondos, limite, error_trans, entregar}), 0);
    model(t, m, r);
    @(negedge clk);
    chk("stb", BW'(balance_stb), BW'(r == R_OK || r == R_DISP));
    chk("fondos", BW'(fondos), BW'(r == R_FON));
    chk("limite", BW'(limite), BW'(r == R_LIM));
    chk("error", BW'(error_trans), BW'(r == R_ERR));
    chk("entregar_start", BW'(entregar), BW'(r == R_DISP));
    chk("balance", balance, m_bal);
    if (r == R_DISP) begin
      for (int i = 1; i <= C; i++) begin
        chk("disp_high", BW'(entregar), 1);
        chk("ready_disp", BW'(trans_ready), 0);
        if (i > 1) chk("quiet_disp", BW'({balance_stb, fondos, limite, error_trans}), 0);
        if (i == rst_at) begin
          reset = 1'b1; tarjeta = 1'b0;
          @(negedge clk);
          reset = 1'b0;
          chk("rst_outputs", BW'({trans_ready, balance_stb, fondos, limite, error_trans, entregar}), 0);
          chk("rst_balance", balance, 0);
          return;
        end
        if (i == drop_at) tarjeta = 1'b0;
        @(negedge clk);
      end
      chk("disp_end", BW'(entregar), 0);
      if (tarjeta) begin
        chk("ready_after_disp", BW'(trans_ready), 1);
        chk("balance_after_disp", balance, m_bal);
      end else begin
        chk("idle_outputs", BW'({trans_ready, balance_stb, fondos, limite, error_trans, entregar}), 0);
        chk("idle_balance", balance, 0);
      end
    end else begin
      chk("ready_after", BW'(trans_ready), 1);
    end
  endtask

  initial begin
    logic [1:0]    rt;
    logic [MW-1:0] rm;
    reset = 1'b1; tarjeta = 1'b0; tv = 1'b0; tipo = 2'd0; monto = '0; bini = '0;
    m_bal = 0; m_ret = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_outputs", BW'({trans_ready, balance_stb, fondos, limite, error_trans, entregar}), 0);
    chk("reset_balance", balance, 0);

    tv = 1'b1; tipo = 2'd2;
    @(negedge clk);
    tv = 1'b0;
    @(negedge clk);
    chk("no_card_ignored", BW'({trans_ready, balance_stb, error_trans}), 0);

    start_session(64'd5000);
    trans(2'd2, 0, 0, 0);
    trans(2'd0, 1500, 0, 0);
    trans(2'd1, 2000, 0, 0);
    trans(2'd1, 4501, 0, 0);
    end_session();

    start_session(64'd200000);
    trans(2'd1, 60000, 0, 0);
    trans(2'd1, 40000, 0, 0);
    trans(2'd1, 1, 0, 0);
    end_session();
    start_session(64'd200000);
    trans(2'd1, 1, 0, 0);
    trans(2'd3, 5, 0, 0);
    trans(2'd0, 0, 0, 0);
    trans(2'd1, 0, 0, 0);
    end_session();

    start_session(64'd3000);
    trans(2'd1, 3000, 0, 0);
    trans(2'd2, 0, 0, 0);
    end_session();

    start_session(64'hFFFF_FFFF_FFFF_FFF6);
    trans(2'd0, 10, 0, 0);
    trans(2'd0, 9, 0, 0);
    end_session();

    start_session(64'd10000);
    trans(2'd1, 100, 2, 0);

    start_session(64'd10000);
    trans(2'd1, 100, 0, 2);
    @(negedge clk);

    for (int k = 0; k < 40; k++) begin
      if (k % 10 == 0) begin
        if (k > 0) end_session();
        start_session(64'($urandom_range(0, 250000)));
      end
      rt = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       rm = '0;
        1:       rm = MW'($urandom_range(1, 1000));
        2:       rm = MW'($urandom_range(1, 150000));
        default: rm = MW'(m_bal);
      endcase
      trans(rt, rm, 0, 0);
    end
    end_session();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/transaccion_multi.md
Name: transaccion_multi

Overview:
Parametrised successor of the ATM transaction unit. It runs a card session with multiple transactions per card: deposit, withdrawal and balance query. It also enforces a per-session cumulative withdrawal limit and drives a timed cash-dispense strobe. It sits between the PIN/card-validation stage, which drives tarjeta_recibida, and the dispenser/account-store back end.

Parameters:
MONTO_W, 32, width of transaction amount
BAL_W, 64, width of account balance
LIMITE_SESION, 100000, max cumulative withdrawal per card session (same units as monto)
ENTREGA_CICLOS, 4, cycles entregar_dinero stays high per accepted withdrawal (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
tarjeta_recibida  input  1  level; high while a validated card is present
trans_valid  input  1  request strobe; sampled only when trans_ready=1
tipo_trans  input  2  00 deposit, 01 withdrawal, 10 balance query, 11 reserved
monto  input  MONTO_W  transaction amount, latched with request
balance_inicial  input  BAL_W  account balance, latched at session start
trans_ready  output  1  unit accepts a request this cycle
balance_actualizado  output  BAL_W  session balance register
balance_stb  output  1  1-cycle pulse: balance_actualizado valid after a successful transaction or query
entregar_dinero  output  1  dispense enable
fondos_insuficientes  output  1  1-cycle pulse: withdrawal rejected, monto > balance
limite_excedido  output  1  1-cycle pulse: withdrawal rejected, session limit exceeded
error_trans  output  1  1-cycle pulse: reserved type, zero amount, or deposit overflow

Behaviour:
- Reset (synchronous, highest priority): state=IDLE. All outputs 0. Balance register and retiro_acum (BAL_W bits) cleared.
- FSM states: IDLE, SESION, EVALUAR, ENTREGA.
- IDLE -> SESION: on the first clk edge with tarjeta_recibida=1.
  - At that edge, balance register <= balance_inicial and retiro_acum <= 0.
  - balance_stb is not pulsed on session start.
- trans_ready=1 only in SESION with tarjeta_recibida=1. trans_valid is ignored in every other case.
- SESION, trans_valid=1 at edge N: latch tipo_trans and monto, go to EVALUAR. trans_ready drops after edge N.
- EVALUAR lasts exactly one cycle. All result outputs are registered at edge N+1 and visible in the cycle after it; latency is 1 cycle from accept.
- Decision rules, all arithmetic done in BAL_W+1 bits:
  - Type 11, or monto==0 on deposit/withdrawal: error_trans pulse; no state change.
  - Deposit: if balance+monto > 2^BAL_W-1, error_trans and balance unchanged. Otherwise balance += monto and balance_stb pulses.
  - Query: balance_stb pulse with unchanged balance.
  - Withdrawal, checks in priority order:
    - monto > balance: fondos_insuficientes.
    - Else retiro_acum+monto > LIMITE_SESION: limite_excedido.
    - Else balance -= monto, retiro_acum += monto, balance_stb pulse, and entregar_dinero=1 starting in the same cycle as balance_stb.
  - Withdrawal equal to the full balance, or reaching LIMITE_SESION exactly, is accepted.
- Next state from EVALUAR: accepted withdrawal -> ENTREGA; all other outcomes -> SESION.
- ENTREGA: a down-counter holds entregar_dinero high for exactly ENTREGA_CICLOS cycles, then returns to SESION. trans_ready=0 throughout.
- At most one of balance_stb / fondos_insuficientes / limite_excedido / error_trans is high in any cycle.
- balance_actualizado holds its value between strobes. It changes only at an EVALUAR edge, a session start, IDLE entry or reset.
- Card removal (tarjeta_recibida=0):
  - In SESION: go to IDLE next edge; balance_actualizado and retiro_acum cleared.
  - In EVALUAR or ENTREGA: the in-flight transaction and the full dispense complete first, then IDLE.
  - A card present on IDLE re-entry starts a new session (new balance_inicial, limit reset).
- Reset mid-dispense: entregar_dinero drops in the cycle after the reset edge.

Test Plan:
- Reset, then card in with balance_inicial=5000, query -> balance_stb 1 cycle after accept, balance_actualizado=5000, trans_ready low exactly 1 cycle.
- Deposit 1500, then withdrawal 2000 -> balances 6500 then 4500. entregar_dinero high exactly 4 cycles, coincident start with balance_stb. trans_ready returns 1 after the 4th cycle.
- Balance 4500, withdrawal 4501 -> fondos_insuficientes pulse only; balance stays 4500; no dispense.
- LIMITE_SESION=100000, balance 200000: withdraw 60000, 40000 (accepted, exact limit), then 1 -> limite_excedido. Card out then in -> 1 accepted again.
- Type 11, and deposit of 0 -> error_trans pulse each. Deposit that overflows with balance=2^64-10, monto=10 -> error_trans, balance unchanged.
- Card removed during the 2nd dispense cycle -> dispense completes all 4 cycles, then IDLE with outputs 0. Separate run: reset during ENTREGA -> all outputs 0 next cycle.
